// File: rtl/mem_stage_nway_if.sv
// Bundle of the pms -> ms -> ws pipeline signals, the flush and the per-lane
// data-cache response signals for one N-lane memory-response stage.
// The master modport is the surrounding pipeline. The slave modport is the stage itself.
interface mem_stage_nway_if #(
    parameter int LANES = 2
);
    logic                  flush;
    logic                  pms_to_ms_valid;
    logic [LANES-1:0]      in_lane_valid;
    logic [7*LANES-1:0]    in_ls_type;
    logic [2*LANES-1:0]    in_offset;
    logic [LANES-1:0]      in_res_from_mem;
    logic [LANES-1:0]      in_mem_we;
    logic [LANES-1:0]      in_gr_we;
    logic [5*LANES-1:0]    in_dest;
    logic [32*LANES-1:0]   in_rt_value;
    logic [32*LANES-1:0]   in_alu_result;
    logic [32*LANES-1:0]   in_pc;
    logic                  ms_allowin;
    logic                  ws_allowin;
    logic [LANES-1:0]      data_ok;
    logic [32*LANES-1:0]   rdata;
    logic                  ms_to_ws_valid;
    logic [LANES-1:0]      out_lane_valid;
    logic [LANES-1:0]      out_gr_we;
    logic [5*LANES-1:0]    out_dest;
    logic [32*LANES-1:0]   out_result;
    logic [32*LANES-1:0]   out_pc;
    logic                  fwd_ms_valid;
    logic [LANES-1:0]      fwd_res_from_mem;

    modport master (
        output flush, pms_to_ms_valid, in_lane_valid, in_ls_type, in_offset,
               in_res_from_mem, in_mem_we, in_gr_we, in_dest, in_rt_value,
               in_alu_result, in_pc, ws_allowin, data_ok, rdata,
        input  ms_allowin, ms_to_ws_valid, out_lane_valid, out_gr_we, out_dest,
               out_result, out_pc, fwd_ms_valid, fwd_res_from_mem
    );

    modport slave (
        input  flush, pms_to_ms_valid, in_lane_valid, in_ls_type, in_offset,
               in_res_from_mem, in_mem_we, in_gr_we, in_dest, in_rt_value,
               in_alu_result, in_pc, ws_allowin, data_ok, rdata,
        output ms_allowin, ms_to_ws_valid, out_lane_valid, out_gr_we, out_dest,
               out_result, out_pc, fwd_ms_valid, fwd_res_from_mem
    );
endinterface

// File: rtl/mem_stage_nway.sv
// N-lane memory-response stage. It holds one issue group, collects each lane's
// data-cache response, and aligns and merges the load data. The group is
// released only when every memory lane has completed. On a flush, responses
// that are still in flight for the killed group are marked for discard, lane
// by lane.
module mem_stage_nway #(
    parameter int LANES = 2
) (
    input logic             clk,
    input logic             reset,
    mem_stage_nway_if.slave bus
);
    logic             ms_valid_reg;
    logic [LANES-1:0] lane_ready;
    logic             ms_ready_go;
    logic             leave;
    logic             ms_allowin;
    logic             accept;

    assign ms_ready_go        = &lane_ready;
    assign leave              = ms_ready_go & bus.ws_allowin;
    assign ms_allowin         = ~ms_valid_reg | leave;
    assign accept             = bus.pms_to_ms_valid & ms_allowin & ~bus.flush;
    assign bus.ms_allowin     = ms_allowin;
    assign bus.ms_to_ws_valid = ms_valid_reg & ms_ready_go & ~bus.flush;
    assign bus.fwd_ms_valid   = ms_valid_reg;

    // Group occupancy: flush kills the group (and any group arriving in the same cycle)
    always_ff @(posedge clk) begin
        if (reset)
            ms_valid_reg <= 1'b0;
        else if (bus.flush)
            ms_valid_reg <= 1'b0;
        else if (accept)
            ms_valid_reg <= 1'b1;
        else if (leave)
            ms_valid_reg <= 1'b0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic        lane_valid_reg, res_from_mem_reg, mem_we_reg, gr_we_reg;
            logic        mem_ok_reg, discard_reg;
            logic [6:0]  ls_type_reg;
            logic [1:0]  offset_reg;
            logic [4:0]  dest_reg;
            logic [31:0] rt_reg, pc_reg, result_reg;
            logic        lane_data_ok, memop, live, capture;
            logic [31:0] lane_rdata, load_data;
            logic [4:0]  shamt;
            logic [7:0]  load_byte;
            logic [15:0] load_half;

            assign lane_data_ok   = bus.data_ok[gi];
            assign lane_rdata     = bus.rdata[32*gi +: 32];
            assign memop          = lane_valid_reg & (res_from_mem_reg | mem_we_reg);
            // A response that belongs to a flushed group is never "live".
            assign live           = lane_data_ok & ~discard_reg;
            assign lane_ready[gi] = ~lane_valid_reg | ~memop | live | mem_ok_reg;
            // Park the response only if the group cannot leave this same cycle.
            assign capture        = live & ms_valid_reg & ~leave;
            assign shamt          = {offset_reg, 3'b000};
            assign load_byte      = 8'(lane_rdata >> shamt);
            assign load_half      = offset_reg[1] ? lane_rdata[31:16] : lane_rdata[15:0];

            // Align the response word by load type and offset (lwl/lwr merge with rt)
            always_comb begin
                load_data = lane_rdata;
                if (ls_type_reg[6])
                    load_data = {{24{load_byte[7]}}, load_byte};
                else if (ls_type_reg[5])
                    load_data = {24'h0, load_byte};
                else if (ls_type_reg[4])
                    load_data = {{16{load_half[15]}}, load_half};
                else if (ls_type_reg[3])
                    load_data = {16'h0, load_half};
                else if (ls_type_reg[2])
                    load_data = lane_rdata;
                else if (ls_type_reg[1])
                    load_data = (lane_rdata << (5'd24 - shamt)) | (rt_reg & (32'h00FF_FFFF >> shamt));
                else if (ls_type_reg[0])
                    load_data = (lane_rdata >> shamt) | (rt_reg & ~(32'hFFFF_FFFF >> shamt));
            end

            // Per-lane state: discard tracking, field load on accept, response capture.
            // result_reg starts as the ALU result so that non-load lanes read it back unchanged.
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_ok_reg  <= 1'b0;
                    discard_reg <= 1'b0;
                end else begin
                    if (discard_reg && lane_data_ok)
                        discard_reg <= 1'b0;
                    else if (bus.flush && ms_valid_reg && memop && !mem_ok_reg && !lane_data_ok)
                        discard_reg <= 1'b1;

                    if (accept) begin
                        lane_valid_reg   <= bus.in_lane_valid[gi];
                        ls_type_reg      <= bus.in_ls_type[7*gi +: 7];
                        offset_reg       <= bus.in_offset[2*gi +: 2];
                        res_from_mem_reg <= bus.in_res_from_mem[gi];
                        mem_we_reg       <= bus.in_mem_we[gi];
                        gr_we_reg        <= bus.in_gr_we[gi];
                        dest_reg         <= bus.in_dest[5*gi +: 5];
                        rt_reg           <= bus.in_rt_value[32*gi +: 32];
                        pc_reg           <= bus.in_pc[32*gi +: 32];
                        result_reg       <= bus.in_alu_result[32*gi +: 32];
                        mem_ok_reg       <= 1'b0;
                    end else if (capture) begin
                        mem_ok_reg <= 1'b1;
                        if (res_from_mem_reg)
                            result_reg <= load_data;
                    end
                end
            end

            assign bus.out_lane_valid[gi]      = lane_valid_reg;
            assign bus.out_gr_we[gi]           = gr_we_reg;
            assign bus.out_dest[5*gi +: 5]     = dest_reg;
            assign bus.out_pc[32*gi +: 32]     = pc_reg;
            assign bus.out_result[32*gi +: 32] = (mem_ok_reg | ~res_from_mem_reg) ? result_reg : load_data;
            assign bus.fwd_res_from_mem[gi]    = res_from_mem_reg;
        end
    endgenerate
endmodule
